// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/writeback,
// waits on a variable-latency memory and traps on illegal opcodes or memory timeouts.
module multicycle_control #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               MemtoReg,
    output logic               PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [1:0]  cause_q, cause_d;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        waiting_s;
    logic        timeout_s;
    logic        unused_s;

    logic        pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;
    logic [3:0]  alu_op_s;

    assign opcode_s  = instruction[6:0];
    assign funct3_s  = instruction[14:12];
    assign unused_s  = ^{instruction[31], instruction[29:15], instruction[11:7]};

    // Memory wait tracking: only FETCH, MEM_RD and MEM_WR wait on mem_ready
    always_comb begin
        waiting_s = 1'b0;
        if ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR)) begin
            waiting_s = ~mem_ready;
        end else begin
            waiting_s = 1'b0;
        end
        timeout_s = waiting_s && (tmo_cnt_q >= TMO_LIMIT);
        tmo_cnt_d = waiting_s ? (tmo_cnt_q + 8'd1) : 8'd0;
    end

    // State, timeout counter and trap cause registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            tmo_cnt_q <= 8'd0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_R:     state_d = S_EXEC_R;
                    OP_I:     state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: begin
                        if (funct3_s == 3'b010) begin
                            state_d = S_MEM_ADDR;
                        end else begin
                            state_d = S_TRAP;
                            cause_d = 2'b01;
                        end
                    end
                    OP_BRANCH: begin
                        if (funct3_s[2:1] == 2'b00) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d = S_TRAP;
                            cause_d = 2'b01;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode_s == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    state_d = state_q;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Output decode from state; fetch and branch enables also look at inputs
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        MemtoReg    = 1'b0;
        PCSrc       = 1'b0;
        alu_op_s    = 4'b0000;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                ALUSrcB    = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b10;
            S_EXEC_R: begin
                ALUSrcA  = 1'b1;
                alu_op_s = {instruction[30], funct3_s};
            end
            S_EXEC_I: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                alu_op_s = {instruction[30] & (funct3_s == 3'b101), funct3_s};
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                IorD       = 1'b1;
                mem_read_s = 1'b1;
            end
            S_MEM_WR: begin
                IorD        = 1'b1;
                mem_write_s = 1'b1;
            end
            S_WB_ALU: reg_write_s = 1'b1;
            S_WB_MEM: begin
                reg_write_s = 1'b1;
                MemtoReg    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_op_s   = 4'b1000;
                PCSrc      = 1'b1;
                pc_write_s = funct3_s[0] ? ~zero : zero;
            end
            S_TRAP:  alu_op_s = 4'b0000;
            default: alu_op_s = 4'b0000;
        endcase
    end

    // Enables forced low during reset so an aborted access issues no writes
    always_comb begin
        PCWrite    = pc_write_s  & ~rst;
        IRWrite    = ir_write_s  & ~rst;
        MemRead    = mem_read_s  & ~rst;
        MemWrite   = mem_write_s & ~rst;
        RegWrite   = reg_write_s & ~rst;
        ALUOp      = '0;
        ALUOp[3:0] = alu_op_s;
        trap       = (state_q == S_TRAP);
        trap_cause = cause_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, trap paths and reset.
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
    logic        IorD, ALUSrcA, MemtoReg, PCSrc, trap;
    logic [1:0]  ALUSrcB, trap_cause;
    logic [3:0]  ALUOp;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BNE  = 32'h00209063;
    localparam logic [31:0] I_BLT  = 32'h0020C063;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .MemtoReg(MemtoReg), .PCSrc(PCSrc), .ALUOp(ALUOp), .trap(trap), .trap_cause(trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}
    function automatic logic [17:0] pat(input logic [4:0] en, input logic iord, input logic asa,
                                        input logic [1:0] asb, input logic m2r, input logic pcs,
                                        input logic [3:0] op, input logic trp, input logic [1:0] cause);
        return {en, iord, asa, asb, m2r, pcs, op, trp, cause};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        #1;
        obs = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, ALUSrcA, ALUSrcB,
               MemtoReg, PCSrc, ALUOp, trap, trap_cause};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // FETCH with a one-cycle memory, then DECODE
    task automatic front(input string tag);
        mem_ready = 1'b1;
        chk({tag, "_fetch"},  pat(5'b11100, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00));
        tick();
        chk({tag, "_decode"}, pat(5'b00000, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00));
        tick();
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; instruction = I_ADD;
        tick(); tick();
        mem_ready = 1'b1;
        chk("reset_enables_low", pat(5'b00000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00));
        rst = 1'b0;

        // add: FETCH, DECODE, EXEC_R, WB_ALU
        front("add");
        chk("add_exec_r", pat(5'b00000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();
        chk("add_wb_alu", pat(5'b00001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();

        instruction = I_SUB;
        front("sub");
        chk("sub_exec_r", pat(5'b00000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'b1000, 1'b0, 2'b00)); tick();
        chk("sub_wb_alu", pat(5'b00001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();

        instruction = I_SRAI;
        front("srai");
        chk("srai_exec_i", pat(5'b00000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'b1101, 1'b0, 2'b00)); tick();
        chk("srai_wb_alu", pat(5'b00001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();

        // lw with three memory wait cycles in MEM_RD
        instruction = I_LW;
        front("lw");
        chk("lw_mem_addr", pat(5'b00000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_rd_wait", pat(5'b00100, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00));
            tick();
        end
        mem_ready = 1'b1;
        chk("lw_mem_rd_done", pat(5'b00100, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();
        chk("lw_wb_mem", pat(5'b00001, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();

        // branches: PCWrite follows zero for beq, ~zero for bne
        instruction = I_BEQ;
        front("beq");
        zero = 1'b1;
        chk("beq_zero1", pat(5'b10000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'b1000, 1'b0, 2'b00));
        zero = 1'b0;
        chk("beq_zero0", pat(5'b00000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'b1000, 1'b0, 2'b00));
        tick();
        instruction = I_BNE;
        front("bne");
        zero = 1'b1;
        chk("bne_zero1", pat(5'b00000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'b1000, 1'b0, 2'b00));
        zero = 1'b0;
        chk("bne_zero0", pat(5'b10000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'b1000, 1'b0, 2'b00));
        tick();

        // sw with a one-cycle memory
        instruction = I_SW;
        front("sw");
        chk("sw_mem_addr", pat(5'b00000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();
        chk("sw_mem_wr", pat(5'b00010, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();

        // illegal opcode traps and stays until reset
        instruction = I_ILL;
        front("ill");
        chk("ill_trap", pat(5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b01)); tick();
        chk("ill_trap_held", pat(5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b01));
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // branch with unsupported funct3 is also illegal
        instruction = I_BLT;
        front("blt_after_rst");
        chk("blt_trap", pat(5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b01));
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // fetch timeout: 16 waiting cycles trap with cause 10
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("fetch_wait", pat(5'b00100, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00));
            tick();
        end
        chk("timeout_trap", pat(5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b10));
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // mem_ready arriving exactly at the limit completes normally
        instruction = I_SW;
        for (int i = 0; i < 15; i++) tick();
        mem_ready = 1'b1;
        chk("limit_fetch_rdy", pat(5'b11100, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();
        chk("limit_decode", pat(5'b00000, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();
        chk("limit_mem_addr", pat(5'b00000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();

        // reset in the middle of a store aborts the write
        mem_ready = 1'b0;
        chk("sw_mem_wr_wait", pat(5'b00010, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();
        rst = 1'b1;
        chk("sw_rst_no_write", pat(5'b00000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00)); tick();
        rst = 1'b0;
        chk("post_rst_fetch", pat(5'b00100, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
